// File: rtl/hcm_access_arbiter.sv
// hcm_access_arbiter
// Sequences one HCM event (IDLE -> FILL -> DRAIN -> READOUT -> CLEAR).
// During FILL it round-robin arbitrates hit writes from NREQ requesters.
// During READOUT it forwards read requests to the HCM.
// All HCM command strobes and addresses are registered one cycle after acceptance.
// Optional feature macro: HCM_ARB_STALLCNT_EN adds a 16-bit saturating stallCount
// output, which counts FILL cycles in which a valid requester was left waiting.
module hcm_access_arbiter #(
    parameter int NREQ             = 4,
    parameter int ROWINDEXBITS_HCM = 10,
    parameter int DRAIN_CYCLES     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             eventStart,
    input  logic                             eventDone,
    input  logic                             readoutDone,
    input  logic [NREQ-1:0]                  hitValid,
    input  logic [NREQ*ROWINDEXBITS_HCM-1:0] hitRow,
    input  logic [NREQ-1:0]                  hitSSIDIsNew,
    output logic [NREQ-1:0]                  hitAccept,
    input  logic                             rdValid,
    input  logic [ROWINDEXBITS_HCM-1:0]      rdRow,
    output logic                             rdAccept,
    input  logic                             hcmReadReady,
    output logic                             hcmWriteRow,
    output logic                             hcmSSIDIsNew,
    output logic                             hcmReadRow,
    output logic [ROWINDEXBITS_HCM-1:0]      hcmRowToWrite,
    output logic [ROWINDEXBITS_HCM-1:0]      hcmRowToRead,
    output logic                             hcmReset,
    output logic [2:0]                       phase,
    output logic                             seqError
`ifdef HCM_ARB_STALLCNT_EN
    ,
    output logic [15:0]                      stallCount
`endif
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        DRAIN   = 3'd2,
        READOUT = 3'd3,
        CLEAR   = 3'd4
    } phaseT;

    phaseT                       state;
    logic [PTRW-1:0]             rrPtr;
    logic [3:0]                  drainCnt;
    logic [NREQ-1:0]             grantVec;
    logic                        grantAny;
    logic [PTRW-1:0]             grantIdx;
    logic [ROWINDEXBITS_HCM-1:0] selRow;
    logic                        selNew;
    logic                        seqViolation;

    // First requester at or after ptr, scanning with wrap-around; one-hot result.
    function automatic logic [NREQ-1:0] pickGrant(input logic [NREQ-1:0] req,
                                                  input logic [PTRW-1:0] ptr);
        logic [NREQ-1:0] onehot;
        logic            found;
        int              idx;
        onehot = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            idx = (idx >= NREQ) ? (idx - NREQ) : idx;
            if (!found && req[idx[PTRW-1:0]]) begin
                onehot[idx[PTRW-1:0]] = 1'b1;
                found                 = 1'b1;
            end else begin
                found = found;
            end
        end
        return onehot;
    endfunction

    // Arbitration is only open in FILL; the winner's row/flag are muxed out here.
    always_comb begin
        grantVec = '0;
        grantIdx = '0;
        selRow   = '0;
        selNew   = 1'b0;
        if (state == FILL) begin
            grantVec = pickGrant(hitValid, rrPtr);
        end else begin
            grantVec = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (grantVec[k]) begin
                grantIdx = PTRW'(k);
                selRow   = hitRow[k*ROWINDEXBITS_HCM +: ROWINDEXBITS_HCM];
                selNew   = hitSSIDIsNew[k];
            end else begin
                grantIdx = grantIdx;
            end
        end
    end

    assign grantAny  = |grantVec;
    assign hitAccept = grantVec;
    assign rdAccept  = rdValid & hcmReadReady & (state == READOUT);
    assign phase     = state;

    assign seqViolation = (eventStart  && (state != IDLE))
                        || (eventDone   && (state != FILL))
                        || (readoutDone && (state != READOUT));

    // Phase sequencing, round-robin pointer, and the registered HCM command outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rrPtr         <= '0;
            drainCnt      <= 4'd0;
            hcmWriteRow   <= 1'b0;
            hcmSSIDIsNew  <= 1'b0;
            hcmReadRow    <= 1'b0;
            hcmRowToWrite <= '0;
            hcmRowToRead  <= '0;
            hcmReset      <= 1'b0;
            seqError      <= 1'b0;
        end else begin
            hcmWriteRow  <= grantAny;
            hcmSSIDIsNew <= grantAny & selNew;
            hcmReadRow   <= rdAccept;
            hcmReset     <= 1'b0;
            if (grantAny) begin
                hcmRowToWrite <= selRow;
                rrPtr         <= (grantIdx == PTRW'(NREQ - 1)) ? '0 : (grantIdx + PTRW'(1));
            end
            if (rdAccept) begin
                hcmRowToRead <= rdRow;
            end
            if (seqViolation) begin
                seqError <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (eventStart) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (eventDone) begin
                        state    <= DRAIN;
                        drainCnt <= 4'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (drainCnt == 4'd0) begin
                        state <= READOUT;
                    end else begin
                        drainCnt <= drainCnt - 4'd1;
                    end
                end
                READOUT: begin
                    if (readoutDone) begin
                        state    <= CLEAR;
                        hcmReset <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HCM_ARB_STALLCNT_EN
    logic stallNow;
    assign stallNow = (state == FILL) && (|(hitValid & ~grantVec));

    // Saturating count of FILL cycles where some valid requester was not served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount <= 16'd0;
        end else if (state == CLEAR) begin
            stallCount <= 16'd0;
        end else if (stallNow && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end else begin
            stallCount <= stallCount;
        end
    end
`endif

endmodule

// File: tb/tb_hcm_access_arbiter.sv
// Directed bench for hcm_access_arbiter. The stimulus process pushes the expected
// HCM write/read commands into queues. A negedge monitor pops them whenever a
// strobe appears.
module tb_hcm_access_arbiter;

    localparam int W = 10;

    logic          clk;
    logic          reset;
    logic          eventStart, eventDone, readoutDone;
    logic [3:0]    hitValid;
    logic [4*W-1:0] hitRow;
    logic [3:0]    hitSSIDIsNew;
    logic [3:0]    hitAccept;
    logic          rdValid;
    logic [W-1:0]  rdRow;
    logic          rdAccept;
    logic          hcmReadReady;
    logic          hcmWriteRow, hcmSSIDIsNew, hcmReadRow;
    logic [W-1:0]  hcmRowToWrite, hcmRowToRead;
    logic          hcmReset;
    logic [2:0]    phase;
    logic          seqError;
`ifdef HCM_ARB_STALLCNT_EN
    logic [15:0]   stallCount;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] wq[$];
    logic [31:0] rq[$];

    // Requester rows and new-SSID flags (r0..r3)
    logic [W-1:0] rowTab[4] = '{10'h011, 10'h0A7, 10'h155, 10'h3C3};
    logic         newTab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    hcm_access_arbiter #(.NREQ(4), .ROWINDEXBITS_HCM(W), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .eventStart(eventStart), .eventDone(eventDone), .readoutDone(readoutDone),
        .hitValid(hitValid), .hitRow(hitRow), .hitSSIDIsNew(hitSSIDIsNew),
        .hitAccept(hitAccept),
        .rdValid(rdValid), .rdRow(rdRow), .rdAccept(rdAccept),
        .hcmReadReady(hcmReadReady),
        .hcmWriteRow(hcmWriteRow), .hcmSSIDIsNew(hcmSSIDIsNew), .hcmReadRow(hcmReadRow),
        .hcmRowToWrite(hcmRowToWrite), .hcmRowToRead(hcmRowToRead),
        .hcmReset(hcmReset), .phase(phase), .seqError(seqError)
`ifdef HCM_ARB_STALLCNT_EN
        , .stallCount(stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWrite(input int i);
        wq.push_back({21'd0, newTab[i], rowTab[i]});
    endtask

    // Monitor: pops the expected command whenever the DUT emits a strobe.
    always @(negedge clk) begin
        if (hcmWriteRow && hcmReadRow) begin
            chk("write_read_overlap", 32'd1, 32'd0);
        end
        if (hcmWriteRow) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {21'd0, hcmSSIDIsNew, hcmRowToWrite}, 32'hFFFF_FFFF);
            end else begin
                chk("write_cmd", {21'd0, hcmSSIDIsNew, hcmRowToWrite}, wq.pop_front());
            end
        end
        if (hcmReadRow) begin
            if (rq.size() == 0) begin
                chk("unexpected_read", {22'd0, hcmRowToRead}, 32'hFFFF_FFFF);
            end else begin
                chk("read_cmd", {22'd0, hcmRowToRead}, rq.pop_front());
            end
        end
    end

    // Bound the run even if the stimulus process stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; eventStart = 1'b0; eventDone = 1'b0; readoutDone = 1'b0;
        hitValid = 4'd0; hitSSIDIsNew = 4'b1010;
        hitRow = {rowTab[3], rowTab[2], rowTab[1], rowTab[0]};
        rdValid = 1'b0; rdRow = '0; hcmReadReady = 1'b0;

        // Reset state
        step(); step(); #3;
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_accept", {28'd0, hitAccept}, 32'd0);
        chk("rst_strobes", {29'd0, hcmWriteRow, hcmReadRow, hcmReset}, 32'd0);
        chk("rst_seqerr", {31'd0, seqError}, 32'd0);
        chk("rst_addr", {12'd0, hcmRowToWrite, hcmRowToRead}, 32'd0);
        reset = 1'b1;

        // Open event; four-way contention granted 0,1,2,3
        step(); eventStart = 1'b1; #3;
        chk("idle_phase", {29'd0, phase}, 32'd0);
        step(); eventStart = 1'b0; hitValid = 4'b1111; #3;
        chk("fill_phase", {29'd0, phase}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step(); #3;
            end
            chk("rr_grant", {28'd0, hitAccept}, 32'(1 << i));
            pushWrite(i);
        end

        // Lone requester 2
        step(); hitValid = 4'b0100; #3;
        chk("lone_grant", {28'd0, hitAccept}, 32'h4);
        pushWrite(2);
        // Pointer now 3: wrap-around to requester 0, then 1
        step(); hitValid = 4'b0011; #3;
        chk("wrap_grant", {28'd0, hitAccept}, 32'h1);
        pushWrite(0);
        step(); #3;
        chk("next_grant", {28'd0, hitAccept}, 32'h2);
        pushWrite(1);
        step(); hitValid = 4'b0000; #3;
        chk("no_grant", {28'd0, hitAccept}, 32'h0);
        // Grant in the same cycle as eventDone still issues
        step(); hitValid = 4'b1000; eventDone = 1'b1; #3;
        chk("done_grant", {28'd0, hitAccept}, 32'h8);
        pushWrite(3);

        // DRAIN lasts 5 cycles with arbitration closed
        for (int i = 0; i < 5; i++) begin
            step(); eventDone = 1'b0; hitValid = 4'b1111; #3;
            chk("drain_phase", {29'd0, phase}, 32'd2);
            chk("drain_accept", {28'd0, hitAccept}, 32'd0);
        end
        step(); hitValid = 4'b0000; #3;
        chk("readout_phase", {29'd0, phase}, 32'd3);

        // Reads wait for hcmReadReady
        for (int i = 0; i < 3; i++) begin
            step(); rdValid = 1'b1; rdRow = 10'h2C3; hcmReadReady = 1'b0; #3;
            chk("rd_blocked", {31'd0, rdAccept}, 32'd0);
        end
        step(); hcmReadReady = 1'b1; #3;
        chk("rd_accept", {31'd0, rdAccept}, 32'd1);
        rq.push_back(32'h2C3);
        step(); rdValid = 1'b0; #3;
        chk("rd_idle", {31'd0, rdAccept}, 32'd0);
        // Read accepted alongside readoutDone still issues
        step(); rdValid = 1'b1; rdRow = 10'h3FF; readoutDone = 1'b1; #3;
        chk("rd_done_accept", {31'd0, rdAccept}, 32'd1);
        chk("no_seqerr", {31'd0, seqError}, 32'd0);
        rq.push_back(32'h3FF);
        step(); rdValid = 1'b0; readoutDone = 1'b0; hcmReadReady = 1'b0; #3;
        chk("clear_phase", {29'd0, phase}, 32'd4);
        chk("clear_hcmreset", {31'd0, hcmReset}, 32'd1);
        step(); #3;
        chk("back_idle", {29'd0, phase}, 32'd0);
        chk("hcmreset_once", {31'd0, hcmReset}, 32'd0);
        chk("hold_rdaddr", {22'd0, hcmRowToRead}, 32'h3FF);
        chk("hold_wraddr", {22'd0, hcmRowToWrite}, 32'h3C3);

        // Stray eventDone in IDLE
        step(); eventDone = 1'b1; #3;
        step(); eventDone = 1'b0; #3;
        chk("seqerr_set", {31'd0, seqError}, 32'd1);
        chk("seqerr_phase", {29'd0, phase}, 32'd0);

        // Reset mid-FILL with a grant pending
        step(); eventStart = 1'b1; #3;
        step(); eventStart = 1'b0; hitValid = 4'b0010; #3;
        chk("pre_rst_grant", {28'd0, hitAccept}, 32'h2);
        pushWrite(1);
        step(); hitValid = 4'b0000; #3;
        step(); hitValid = 4'b0100; #3;
        chk("rst_cycle_grant", {28'd0, hitAccept}, 32'h4);
        reset = 1'b0; #1;
        chk("async_phase", {29'd0, phase}, 32'd0);
        chk("async_seqerr", {31'd0, seqError}, 32'd0);
        hitValid = 4'b0000;
        step(); #3;
        chk("rst_no_write", {31'd0, hcmWriteRow}, 32'd0);
        chk("rst_no_hcmreset", {31'd0, hcmReset}, 32'd0);
        chk("rst_wraddr", {22'd0, hcmRowToWrite}, 32'd0);
        reset = 1'b1;
        // Pointer back at 0
        step(); eventStart = 1'b1; #3;
        step(); eventStart = 1'b0; hitValid = 4'b1111; #3;
        chk("ptr_reset_grant", {28'd0, hitAccept}, 32'h1);
        pushWrite(0);
        step(); hitValid = 4'b0000; #3;
        step(); #3;
        step(); #3;

        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("read_queue_empty", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
